serialdump: RTL
===============

Name: serialdump

Overview:
- Reads a block of 32-bit words from memory and sends them out the UART transmitter as ASCII hexadecimal, then sends one terminating blank (0x20).
- Its output format is the same one serialboot accepts on input. A dump can therefore be loaded back unchanged.
- Sits between the CPU bus and the memory controller, like serialboot. It overrides the memory address and read strobe while a dump is running; the CPU hangs on ready_cpu until the dump finishes.

Parameters:
- HEX_UPPER, 0, 1 selects 'A'-'F' for digits 10-15; 0 selects 'a'-'f'.
- ADDR_STEP, 4, byte increment applied to the memory address after each word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a  in  3  control register select
- d  in  32  control write data
- we  in  1  control write strobe
- ready  out  1  control port idle
- a_cpu  in  32  CPU address
- d_cpu  in  32  CPU write data
- we_cpu  in  1  CPU write strobe
- rd_cpu  in  1  CPU read strobe
- spo_cpu  out  32  CPU read data
- ready_cpu  out  1  CPU ready
- a_mem  out  32  memory address
- d_mem  out  32  memory write data
- we_mem  out  1  memory write strobe
- rd_mem  out  1  memory read strobe
- spo_mem  in  32  memory read data
- ready_mem  in  1  memory idle / data valid
- uart_tx_data  out  8  byte to transmit
- uart_tx_req  out  1  one-cycle send pulse
- uart_tx_ready  in  1  transmitter idle

Behaviour:
- Control writes are accepted only in IDLE; writes in any other state are ignored.
  - a=3'b001: start address = {d[7:0],d[15:8],d[23:16],d[31:24]} (byte-reversed).
  - a=3'b010: word count, byte-reversed the same way.
  - a=3'b011: start the dump.
- ready = (state==IDLE) & !we.
- Bus mux, with override = (state!=IDLE):
  - a_mem = override ? dump_a : a_cpu; rd_mem = override ? dump_rd : rd_cpu.
  - we_mem = override ? 0 : we_cpu; d_mem = d_cpu.
  - spo_cpu = spo_mem; ready_cpu = override ? 0 : ready_mem.
- Reset values: state IDLE, dump_rd 0, uart_tx_req 0, uart_tx_data 0, address 0, count 0, nibble index 0.
- State machine:
  - IDLE: on start, go to TERM if count==0, otherwise go to RD.
  - RD: when ready_mem=1, assert dump_rd for exactly one cycle, then go to RDGUARD.
  - RDGUARD: hold one cycle with ready_mem ignored, then go to RDWAIT.
  - RDWAIT: when ready_mem=1, latch spo_mem into the word register, set nibble index to 0, go to SEND.
  - SEND: when uart_tx_ready=1, drive uart_tx_data = ASCII(word[31-4i -: 4]) (most significant nibble first) and pulse uart_tx_req for one cycle, then go to TXGUARD.
  - TXGUARD: hold one cycle, then go to TXWAIT.
  - TXWAIT: when uart_tx_ready=1:
    - if nibble index < 7, increment it and go to SEND;
    - otherwise add ADDR_STEP to the address (wraps at 2^32), decrement count, and go to TERM if the new count is 0, else RD.
  - TERM: when uart_tx_ready=1, send 0x20, then go to TERMGUARD.
  - TERMGUARD: hold one cycle, then go to TERMWAIT.
  - TERMWAIT: when uart_tx_ready=1, go to IDLE.
- ASCII mapping: 0-9 → 0x30+n; 10-15 → 0x61+(n-10), or 0x41+(n-10) when HEX_UPPER=1.
- There are no separators between words. Output is exactly 8*count+1 bytes.
- uart_tx_data holds its value until the next pulse.
- CPU accesses issued during a dump stall. They do not reach memory until the dump returns to IDLE.
- Reset asserted mid-operation aborts at once:
  - state returns to IDLE and override drops in the same cycle;
  - no terminator is sent and the remaining data is dropped.
- A count of 0xFFFFFFFF is legal; the count is 32-bit unsigned.

Decomposition:
- Shared package:
  - control register addresses (SD_REG_ADDR=3'b001, SD_REG_CNT=3'b010, SD_REG_GO=3'b011);
  - terminator constant 8'h20;
  - state enum.
- Sub-module hex2ascii: combinational 4-bit to 8-bit converter with the HEX_UPPER parameter. serialboot's decoder has a natural counterpart to it.

Test Plan:
- Address 0x100 (written as d=0x00010000), count 1, mem[0x100]=0xDEADBEEF, tx always ready → sends "deadbeef" then 0x20; a_mem=0x100; exactly one rd_mem pulse.
- Count 0, then go → only 0x20 is sent; no rd_mem pulse; ready returns high.
- Count 2, mem[0x0]=0x0123ABCD, mem[0x4]=0x89ABCDEF, HEX_UPPER=1 → sends "0123ABCD89ABCDEF" then 0x20; addresses 0x0 then 0x4.
- Memory that stalls 20 cycles per read and a transmitter that stays busy 10 cycles per byte → same byte stream; uart_tx_req never pulses while uart_tx_ready=0; CPU reads issued during the dump see ready_cpu=0.
- Reset after 3 bytes of a 4-word dump → next cycle: state IDLE, rd_mem follows rd_cpu, no further uart_tx_req pulses.
- Address 0xFFFFFFFC, count 2 → second read at 0x00000000 (wrap-around).

Source files
------------

// File: rtl/serialdump_pkg.sv
// serialdump_pkg: shared register map, terminator byte and FSM states for serialdump
package serialdump_pkg;
  localparam logic [2:0] SD_REG_ADDR = 3'b001;
  localparam logic [2:0] SD_REG_CNT  = 3'b010;
  localparam logic [2:0] SD_REG_GO   = 3'b011;
  localparam logic [7:0] SD_TERM     = 8'h20;
  typedef enum logic [3:0] {
    IDLE, RD, RDGUARD, RDWAIT, SEND, TXGUARD, TXWAIT, TERM, TERMGUARD, TERMWAIT
  } sd_state_t;
  function automatic logic [31:0] byterev(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
endpackage

// File: rtl/serialdump_hex2ascii.sv
// hex2ascii: one hex nibble to its ASCII digit, letter case chosen by HEX_UPPER
module hex2ascii #(
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  assign ascii = nib < 4'd10 ? 8'h30 + {4'h0, nib}
                             : (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
endmodule

// File: rtl/serialdump.sv
// serialdump: dumps a block of memory words to the UART as hex text ending in one blank
module serialdump
  import serialdump_pkg::*;
#(
  parameter bit          HEX_UPPER = 1'b0,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic        ready,
  input  logic [31:0] a_cpu,
  input  logic [31:0] d_cpu,
  input  logic        we_cpu,
  input  logic        rd_cpu,
  output logic [31:0] spo_cpu,
  output logic        ready_cpu,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_req,
  input  logic        uart_tx_ready
);
  sd_state_t   state, state_nx;
  logic [31:0] addr, cnt, word;
  logic [2:0]  nib;
  logic [3:0]  cur_nib;
  logic [7:0]  hex;
  logic        dump_rd, override, idle_we, tx_fire;
  assign override  = state != IDLE;
  assign idle_we   = state == IDLE && we;
  assign ready     = state == IDLE && !we;
  assign a_mem     = override ? addr : a_cpu;
  assign rd_mem    = override ? dump_rd : rd_cpu;
  assign we_mem    = override ? 1'b0 : we_cpu;
  assign d_mem     = d_cpu;
  assign spo_cpu   = spo_mem;
  assign ready_cpu = override ? 1'b0 : ready_mem;
  assign tx_fire   = (state == SEND || state == TERM) && uart_tx_ready;
  // ~nib walks the nibbles from the most significant one down
  assign cur_nib   = word[{~nib, 2'b00} +: 4];
  hex2ascii #(.HEX_UPPER(HEX_UPPER)) u_hex (.nib(cur_nib), .ascii(hex));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (idle_we && a == SD_REG_GO) state_nx = cnt == '0 ? TERM : RD;
      RD:        if (ready_mem) state_nx = RDGUARD;
      RDGUARD:   state_nx = RDWAIT;
      RDWAIT:    if (ready_mem) state_nx = SEND;
      SEND:      if (uart_tx_ready) state_nx = TXGUARD;
      TXGUARD:   state_nx = TXWAIT;
      TXWAIT:    if (uart_tx_ready) state_nx = nib != 3'd7 ? SEND : cnt == 32'd1 ? TERM : RD;
      TERM:      if (uart_tx_ready) state_nx = TERMGUARD;
      TERMGUARD: state_nx = TERMWAIT;
      TERMWAIT:  if (uart_tx_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      cnt          <= '0;
      word         <= '0;
      nib          <= '0;
      dump_rd      <= 1'b0;
      uart_tx_req  <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      dump_rd     <= state == RD && ready_mem;
      uart_tx_req <= tx_fire;
      if (tx_fire) uart_tx_data <= state == SEND ? hex : SD_TERM;
      if (idle_we && a == SD_REG_ADDR) addr <= byterev(d);
      if (idle_we && a == SD_REG_CNT) cnt <= byterev(d);
      if (state == RDWAIT && ready_mem) begin
        word <= spo_mem;
        nib  <= '0;
      end
      if (state == TXWAIT && uart_tx_ready) begin
        nib <= nib + 3'd1;
        if (nib == 3'd7) begin
          addr <= addr + ADDR_STEP;
          cnt  <= cnt - 32'd1;
        end
      end
    end
  end
endmodule
